// File: rtl/traffic_sensor_conditioner_if.sv
// Sensor-side bundle for traffic_sensor_conditioner: raw sensor levels in, conditioned
// density / emergency outputs out. The DUT takes the slave modport; the driver takes the master modport.
interface traffic_sensor_conditioner_if;
    logic [11:0] ir_raw;
    logic [3:0]  snd_raw;
    logic [11:0] ir_clean;
    logic [3:0]  density;
    logic        heavy;
    logic [3:0]  emg_req;
    logic        emg_active;

    modport master (
        output ir_raw, snd_raw,
        input  ir_clean, density, heavy, emg_req, emg_active
    );

    modport slave (
        input  ir_raw, snd_raw,
        output ir_clean, density, heavy, emg_req, emg_active
    );
endinterface

// File: rtl/traffic_sensor_conditioner.sv
// Debounces 12 IR sensors into a density count / heavy flag and qualifies 4 sound sensors into
// a priority-resolved emergency request with hold-off. Define SENSOR_SYNC_EN to add 2-flop input synchronizers.
module traffic_sensor_conditioner #(
    parameter int DEB_CYCLES   = 4,
    parameter int EMG_QUAL     = 8,
    parameter int EMG_HOLD     = 16,
    parameter int DENSE_THRESH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    traffic_sensor_conditioner_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, QUALIFY, ACTIVE} emg_state_t;

    logic [11:0] w_ir_s;
    logic [3:0]  w_snd_s;

`ifdef SENSOR_SYNC_EN
    logic [11:0] r_ir_meta, r_ir_sync;
    logic [3:0]  r_snd_meta, r_snd_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ir_meta  <= '0;
            r_ir_sync  <= '0;
            r_snd_meta <= '0;
            r_snd_sync <= '0;
        end else begin
            r_ir_meta  <= bus.ir_raw;
            r_ir_sync  <= r_ir_meta;
            r_snd_meta <= bus.snd_raw;
            r_snd_sync <= r_snd_meta;
        end
    end

    assign w_ir_s  = r_ir_sync;
    assign w_snd_s = r_snd_sync;
`else
    assign w_ir_s  = bus.ir_raw;
    assign w_snd_s = bus.snd_raw;
`endif

    // ---------------- IR debounce and density ----------------
    logic [11:0] r_ir_clean;
    logic [3:0]  r_dc [12];
    logic [3:0]  r_density;
    logic        r_heavy;
    logic [3:0]  w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ir_clean <= '0;
            // NOTE: r_dc is a small register array of counters, so it is reset element by element;
            // a real RAM would not be given a reset.
            for (int i = 0; i < 12; i++) r_dc[i] <= '0;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
            for (int i = 0; i < 12; i++) begin
                if (w_ir_s[i] == r_ir_clean[i]) begin
                    r_dc[i] <= '0;
                end else if (r_dc[i] == 4'(DEB_CYCLES - 1)) begin
                    r_ir_clean[i] <= w_ir_s[i];
                    r_dc[i]       <= '0;
                end else begin
                    r_dc[i] <= r_dc[i] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < 12; i++) w_pop = w_pop + 4'(r_ir_clean[i]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_density <= '0;
            r_heavy   <= 1'b0;
        end else begin
            r_density <= w_pop;
            r_heavy   <= (32'(w_pop) >= DENSE_THRESH);
        end
    end

    // ---------------- Emergency qualification FSM ----------------
    emg_state_t r_state, w_state_nxt;
    logic [1:0] r_cand, w_cand_nxt;
    logic [7:0] r_qc, w_qc_nxt;
    logic [7:0] r_hc, w_hc_nxt;
    logic [3:0] w_emg_req;

    function automatic logic [1:0] hi_idx(input logic [3:0] s);
        if (s[3])      return 2'd3;
        else if (s[2]) return 2'd2;
        else if (s[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cand  <= '0;
            r_qc    <= '0;
            r_hc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_qc    <= w_qc_nxt;
            r_hc    <= w_hc_nxt;
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no branch leaves one unassigned,
        // which would infer a latch.
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_qc_nxt    = r_qc;
        w_hc_nxt    = r_hc;
        case (r_state)
            IDLE: begin
                if (|w_snd_s) begin
                    w_cand_nxt = hi_idx(w_snd_s);
                    if (EMG_QUAL == 1) begin
                        w_state_nxt = ACTIVE;
                        w_hc_nxt    = 8'(EMG_HOLD);
                    end else begin
                        w_state_nxt = QUALIFY;
                        w_qc_nxt    = 8'd1;
                    end
                end
            end
            QUALIFY: begin
                // The candidate is locked; other channels are ignored until the FSM returns to IDLE.
                if (!w_snd_s[r_cand]) begin
                    w_state_nxt = IDLE;
                    w_qc_nxt    = '0;
                end else if (r_qc == 8'(EMG_QUAL - 1)) begin
                    w_state_nxt = ACTIVE;
                    w_qc_nxt    = '0;
                    w_hc_nxt    = 8'(EMG_HOLD);
                end else begin
                    w_qc_nxt = r_qc + 8'd1;
                end
            end
            ACTIVE: begin
                if (w_snd_s[r_cand]) begin
                    w_hc_nxt = 8'(EMG_HOLD);
                end else if (r_hc == 8'd1) begin
                    w_state_nxt = IDLE;
                    w_hc_nxt    = '0;
                end else begin
                    w_hc_nxt = r_hc - 8'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_emg_req = (r_state == ACTIVE) ? (4'b0001 << r_cand) : 4'b0000;

    assign bus.ir_clean   = r_ir_clean;
    assign bus.density    = r_density;
    assign bus.heavy      = r_heavy;
    assign bus.emg_req    = w_emg_req;
    assign bus.emg_active = |w_emg_req;
endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench for traffic_sensor_conditioner with default parameters and SENSOR_SYNC_EN undefined:
// a per-cycle IR vector table plus hand sequences for emergency qualification, hold-off and reset.
module tb_traffic_sensor_conditioner;
    logic clk;
    logic reset;

    traffic_sensor_conditioner_if sif ();

    traffic_sensor_conditioner dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] ir;
        logic [3:0]  snd;
        logic [11:0] exp_clean;
        logic [3:0]  exp_density;
        logic        exp_heavy;
        logic [3:0]  exp_emg;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 'h%0h, expected 'h%0h", name, $time, act, exp);
        end
    endtask

    task automatic add(input logic [11:0] ir, input logic [3:0] snd, input logic [11:0] c,
                       input logic [3:0] d, input logic h, input logic [3:0] e);
        vec_t v;
        v.ir = ir; v.snd = snd; v.exp_clean = c; v.exp_density = d; v.exp_heavy = h; v.exp_emg = e;
        vecs.push_back(v);
    endtask

    task automatic addn(input int n, input logic [11:0] ir, input logic [3:0] snd, input logic [11:0] c,
                        input logic [3:0] d, input logic h, input logic [3:0] e);
        for (int i = 0; i < n; i++) add(ir, snd, c, d, h, e);
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit after the next edge.
    task automatic step(input logic [11:0] ir, input logic [3:0] snd);
        sif.ir_raw  = ir;
        sif.snd_raw = snd;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [11:0] c, input logic [3:0] d,
                             input logic h, input logic [3:0] e);
        check({tag, ".ir_clean"},   32'(sif.ir_clean),   32'(c));
        check({tag, ".density"},    32'(sif.density),    32'(d));
        check({tag, ".heavy"},      32'(sif.heavy),      32'(h));
        check({tag, ".emg_req"},    32'(sif.emg_req),    32'(e));
        check({tag, ".emg_active"}, 32'(sif.emg_active), 32'(|e));
    endtask

    initial begin
        // Cycle-by-cycle IR table: held pattern, short glitches, threshold crossing both ways.
        addn(3, 12'h00F, 4'h0, 12'h000, 4'd0, 1'b0, 4'h0);
        add (   12'h00F, 4'h0, 12'h00F, 4'd0, 1'b0, 4'h0);
        add (   12'h00F, 4'h0, 12'h00F, 4'd4, 1'b0, 4'h0);
        addn(3, 12'h000, 4'h0, 12'h00F, 4'd4, 1'b0, 4'h0);
        add (   12'h000, 4'h0, 12'h000, 4'd4, 1'b0, 4'h0);
        add (   12'h000, 4'h0, 12'h000, 4'd0, 1'b0, 4'h0);
        addn(3, 12'h001, 4'h0, 12'h000, 4'd0, 1'b0, 4'h0);
        add (   12'h000, 4'h0, 12'h000, 4'd0, 1'b0, 4'h0);
        addn(3, 12'h001, 4'h0, 12'h000, 4'd0, 1'b0, 4'h0);
        add (   12'h000, 4'h0, 12'h000, 4'd0, 1'b0, 4'h0);
        addn(3, 12'hFF0, 4'h0, 12'h000, 4'd0, 1'b0, 4'h0);
        add (   12'hFF0, 4'h0, 12'hFF0, 4'd0, 1'b0, 4'h0);
        addn(2, 12'hFF0, 4'h0, 12'hFF0, 4'd8, 1'b1, 4'h0);
        addn(3, 12'h0F0, 4'h0, 12'hFF0, 4'd8, 1'b1, 4'h0);
        add (   12'h0F0, 4'h0, 12'h0F0, 4'd8, 1'b1, 4'h0);
        add (   12'h0F0, 4'h0, 12'h0F0, 4'd4, 1'b0, 4'h0);
        addn(3, 12'h0FE, 4'h0, 12'h0F0, 4'd4, 1'b0, 4'h0);
        add (   12'h0FE, 4'h0, 12'h0FE, 4'd4, 1'b0, 4'h0);
        add (   12'h0FE, 4'h0, 12'h0FE, 4'd7, 1'b0, 4'h0);
        addn(3, 12'h1FE, 4'h0, 12'h0FE, 4'd7, 1'b0, 4'h0);
        add (   12'h1FE, 4'h0, 12'h1FE, 4'd7, 1'b0, 4'h0);
        add (   12'h1FE, 4'h0, 12'h1FE, 4'd8, 1'b1, 4'h0);

        // Reset with inputs held low.
        reset       = 1'b1;
        sif.ir_raw  = '0;
        sif.snd_raw = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all("in_reset", 12'h000, 4'd0, 1'b0, 4'h0);
        reset = 1'b0;
        step(12'h000, 4'h0);
        check_all("post_reset", 12'h000, 4'd0, 1'b0, 4'h0);

        foreach (vecs[i]) begin
            step(vecs[i].ir, vecs[i].snd);
            check_all($sformatf("vec%0d", i), vecs[i].exp_clean, vecs[i].exp_density,
                      vecs[i].exp_heavy, vecs[i].exp_emg);
        end

        // Two simultaneous bits: highest index wins, active after the 8th high edge.
        for (int k = 1; k <= 8; k++) begin
            step(12'h1FE, 4'b0110);
            check($sformatf("qual_0110_k%0d", k), 32'(sif.emg_req), (k == 8) ? 32'h4 : 32'h0);
            check($sformatf("qual_0110_act_k%0d", k), 32'(sif.emg_active), 32'(k == 8));
        end
        step(12'h1FE, 4'b0110);
        check("active_hold_high", 32'(sif.emg_req), 32'h4);
        check("ir_indep_density", 32'(sif.density), 32'd8);

        // Higher-priority pulse while ACTIVE must not preempt; candidate bit is low meanwhile.
        for (int k = 1; k <= 2; k++) begin
            step(12'h1FE, 4'b1000);
            check($sformatf("no_preempt_k%0d", k), 32'(sif.emg_req), 32'h4);
        end
        step(12'h1FE, 4'b0100);
        check("hold_reload", 32'(sif.emg_req), 32'h4);

        // Release only after the 16th consecutive low sample.
        for (int k = 1; k <= 16; k++) begin
            step(12'h1FE, 4'b0000);
            check($sformatf("hold_k%0d", k), 32'(sif.emg_req), (k < 16) ? 32'h4 : 32'h0);
            check($sformatf("hold_act_k%0d", k), 32'(sif.emg_active), 32'(k < 16));
        end

        // 7 highs then a low abandons qualification; a fresh run of 8 qualifies.
        for (int k = 1; k <= 7; k++) begin
            step(12'h1FE, 4'b0001);
            check($sformatf("short_run_k%0d", k), 32'(sif.emg_active), 32'd0);
        end
        step(12'h1FE, 4'b0000);
        check("short_run_drop", 32'(sif.emg_active), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            step(12'h1FE, (k == 3 || k == 4) ? 4'b1001 : 4'b0001);
            check($sformatf("requal_k%0d", k), 32'(sif.emg_req), (k == 8) ? 32'h1 : 32'h0);
        end
        step(12'h1FE, 4'b0001);
        check("requal_hold", 32'(sif.emg_req), 32'h1);

        // Asynchronous reset mid-ACTIVE clears everything without waiting for an edge.
        #2;
        reset = 1'b1;
        #1;
        check_all("async_reset", 12'h000, 4'd0, 1'b0, 4'h0);
        sif.ir_raw  = '0;
        sif.snd_raw = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(12'h000, 4'h0);
        check_all("after_async_reset", 12'h000, 4'd0, 1'b0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/traffic_sensor_conditioner.md
Name: traffic_sensor_conditioner

Overview:
Front-end conditioning stage for the intersection traffic light controller. It debounces the 12 raw IR density sensors and produces a registered vehicle count plus a heavy-traffic flag. It qualifies the 4 raw sound sensors into a single stable, priority-resolved emergency request with hold-off. Its outputs drive the controller's mode selection (four-stage / two-stage / emergency) directly.

Parameters:
DEB_CYCLES, 4, consecutive differing samples required before an IR clean bit flips; legal range 1..15
EMG_QUAL, 8, consecutive high samples of the candidate sound bit required to declare an emergency; legal range 1..255
EMG_HOLD, 16, consecutive low samples of the active sound bit before the emergency is released; legal range 1..255
DENSE_THRESH, 8, density value at or above which heavy asserts; legal range 0..12

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
ir_raw  input  12  raw IR sensor levels, 1 = vehicle present
snd_raw  input  4  raw sound sensor levels; bit3 is the highest priority, bit0 the lowest
ir_clean  output  12  debounced IR levels, registered
density  output  4  popcount of ir_clean, registered, range 0..12
heavy  output  1  registered; 1 when popcount(ir_clean) >= DENSE_THRESH
emg_req  output  4  one-hot active emergency channel, all zeros when none is active
emg_active  output  1  equals |emg_req

Behaviour:
- Reset is asynchronous, active-high, on the clk domain. While it is asserted:
  - ir_clean=0, density=0, heavy=0, emg_req=0, emg_active=0.
  - All counters are 0 and the FSM is in IDLE.
  - Reset mid-operation abandons any qualification or hold immediately.
- The sampled inputs are ir_s and snd_s. With the optional feature off, they are ir_raw and snd_raw directly.
- IR debounce, independent per bit i, with counter dc[i] of width 4:
  - If ir_s[i] == ir_clean[i], then dc[i] <= 0.
  - Else, if dc[i] == DEB_CYCLES-1, then ir_clean[i] <= ir_s[i] and dc[i] <= 0.
  - Else, dc[i] <= dc[i]+1.
  - A change therefore appears on ir_clean at the DEB_CYCLES-th consecutive differing sample edge.
  - A glitch shorter than DEB_CYCLES samples never reaches ir_clean.
- Density:
  - Each edge, density <= popcount(ir_clean current value) and heavy <= (that popcount >= DENSE_THRESH).
  - Density and heavy lag ir_clean by exactly 1 cycle and always update together.
- Emergency FSM, states IDLE, QUALIFY, ACTIVE. Register cand (2b) holds the candidate channel, qc (8b) counts qualifying samples, hc (8b) counts hold-off samples.
- IDLE:
  - If snd_s is nonzero, cand <= index of the highest set bit.
  - If EMG_QUAL==1, go to ACTIVE with hc <= EMG_HOLD.
  - Otherwise go to QUALIFY with qc <= 1.
  - The FSM never enters QUALIFY or ACTIVE on the same edge it leaves one of them; a new request is first sampled in IDLE on the next edge.
- QUALIFY:
  - If snd_s[cand]==0, go to IDLE with qc <= 0.
  - Else, if qc == EMG_QUAL-1, go to ACTIVE with hc <= EMG_HOLD.
  - Else, qc <= qc+1.
  - Other snd bits are ignored in this state; the candidate is fixed once chosen.
- ACTIVE:
  - emg_req = one-hot(cand), driven from registered state.
  - If snd_s[cand]==1, hc <= EMG_HOLD.
  - Else, if hc == 1, go to IDLE.
  - Else, hc <= hc-1.
  - There is no preemption by a higher-priority channel while ACTIVE.
- Emergency timing:
  - emg_active rises after the EMG_QUAL-th consecutive high sample edge.
  - emg_active falls after the EMG_HOLD-th consecutive low sample edge.
- Simultaneous bits in IDLE: the highest index wins, e.g. snd_raw=4'b0110 selects cand=2.
- IR and emergency paths are fully independent.

Optional Feature:
SENSOR_SYNC_EN
- Defined: ir_raw and snd_raw each pass through a 2-flop synchronizer, reset to 0, before use as ir_s/snd_s. Every latency above increases by exactly 2 cycles.
- Undefined: the inputs are used directly, with no added latency. The source must then be synchronous to clk.

Test Plan:
1. Reset release, inputs held 0 -> all outputs 0. Assert reset mid-ACTIVE -> emg_req=0 immediately, with no wait for a clock edge.
2. ir_raw=12'h00F held from edge 1 -> ir_clean=12'h00F after edge 4, density=4 after edge 5, heavy=0.
3. ir_raw=12'h001 for 3 cycles, then 0 -> ir_clean stays 0 and density stays 0 throughout.
4. ir_raw=12'hFF0 held -> density=8 and heavy=1 after edge 5. Then ir_raw=12'h0F0 -> heavy=0 five edges later, density=4.
5. snd_raw=4'b0110 held for 8 samples -> emg_req=4'b0100 and emg_active=1 after the 8th edge. Then snd_raw=0 -> emg_req drops after the 16th low edge. An additional pulse on bit3 during ACTIVE leaves emg_req unchanged.
6. snd_raw=4'b0001 high for 7 samples, then low for 1, then high for 8 -> no emergency after the first 7. emg_req=4'b0001 only after the 8th sample of the second run. With SENSOR_SYNC_EN defined, every response in scenarios 2-6 occurs 2 cycles later.
